// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement scheduler: one-hot direction codes,
// the step FSM state type and the 180-degree reversal test.
package snake_pkg;

  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;
  localparam logic [3:0] DIR_RESET = DIR_RIGHT;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    ISSUE
  } state_t;

  // True when a and b point in opposite directions on the same axis.
  function automatic logic is_reverse(input logic [3:0] a, input logic [3:0] b);
    return (a == DIR_LEFT  && b == DIR_RIGHT) || (a == DIR_RIGHT && b == DIR_LEFT) ||
           (a == DIR_UP    && b == DIR_DOWN)  || (a == DIR_DOWN  && b == DIR_UP);
  endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// Stability filter for one already-synchronized button: the output follows the
// input only after it has differed for DEB_CYCLES consecutive cycles.
module snake_btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: filters button requests against the committed direction
// and issues periodic steps over valid/ready. Optional debounce: DEBOUNCE_EN.
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int DIV_W      = 25,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [3:0] direction,
  output logic       overrun
);

  if (DEB_CYCLES < 1 || (DIV_W < 31 && (1 << DIV_W) <= TICK_DIV)) begin : g_bad_params
    $error("snake_move_scheduler: DIV_W too small for TICK_DIV or DEB_CYCLES < 1");
  end

  logic [3:0] btn_p0;
  logic [3:0] btn_p1;
  logic [3:0] btn_clean;
  logic [3:0] req;

  // Stage p0/p1: two-flop synchronizer on the raw buttons
  always_ff @(posedge clk) begin
    btn_p0 <= {down, up, right, left};
    btn_p1 <= btn_p0;
  end

`ifdef DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_deb
    snake_btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_p1[i]),
      .dout (btn_clean[i])
    );
  end
`else
  assign btn_clean = btn_p1;
`endif

  always_comb begin
    req = '0;
    if (btn_clean[0])      req = DIR_LEFT;
    else if (btn_clean[1]) req = DIR_RIGHT;
    else if (btn_clean[2]) req = DIR_UP;
    else if (btn_clean[3]) req = DIR_DOWN;
  end

  logic [DIV_W-1:0] period_shift;
  logic [DIV_W-1:0] period_next;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] counter;
  logic             at_end;
  logic [3:0]       pending;
  state_t           state;

  assign period_shift = DIV_W'(TICK_DIV >> speed);
  assign period_next  = (period_shift == '0) ? DIV_W'(1) : period_shift;
  assign at_end       = (counter == period - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      period     <= period_next;
      step_valid <= 1'b0;
      overrun    <= 1'b0;
      direction  <= DIR_RESET;
      pending    <= DIR_RESET;
    end else begin
      // Reversal is judged against the committed direction before this edge
      if (req != '0 && !is_reverse(req, direction)) pending <= req;

      case (state)
        IDLE: begin
          counter <= '0;
          if (enable) begin
            state  <= COUNT;
            period <= period_next;
          end
        end
        COUNT: begin
          if (!enable) begin
            state   <= IDLE;
            counter <= '0;
          end else if (at_end) begin
            state      <= ISSUE;
            counter    <= '0;
            period     <= period_next;
            step_valid <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        ISSUE: begin
          if (step_ready) begin
            // The step commits the pending value seen before this edge
            direction  <= pending;
            step_valid <= 1'b0;
            counter    <= '0;
            period     <= period_next;
            state      <= enable ? COUNT : IDLE;
          end else if (at_end) begin
            overrun <= 1'b1;
            counter <= '0;
            period  <= period_next;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          counter    <= '0;
          step_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Self-checking bench for snake_move_scheduler (TICK_DIV=8, DIV_W=4, no debounce)
// using a step/period reference model built from the behavioural rules.
module tb_snake_move_scheduler;

  logic       clk;
  logic       rst_n;
  logic       left, right, up, down;
  logic       enable;
  logic [1:0] speed;
  logic       step_ready;
  logic       step_valid;
  logic [3:0] direction;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  snake_move_scheduler #(
    .TICK_DIV(8),
    .DIV_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .left      (left),
    .right     (right),
    .up        (up),
    .down      (down),
    .enable    (enable),
    .speed     (speed),
    .step_ready(step_ready),
    .step_valid(step_valid),
    .direction (direction),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_dir, m_pend, s1, s2;
  bit         m_out, m_ovr, m_run;
  int         rem;

  function automatic logic [3:0] prio(input logic [3:0] b);
    if (b[0]) return 4'b0001;
    if (b[1]) return 4'b0010;
    if (b[2]) return 4'b0100;
    if (b[3]) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0001;
      4'b0100: return 4'b1000;
      4'b1000: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int period_of(input logic [1:0] s);
    int p;
    p = 8 >> s;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_dir  = 4'b0010;
    m_pend = 4'b0010;
    m_out  = 0;
    m_ovr  = 0;
    m_run  = 0;
    rem    = 0;
  endtask

  // One clock edge of the reference, using the input values held before the edge
  task automatic model_edge();
    logic [3:0] rq, old_pend;
    int p;
    rq = prio(s2);
    s2 = s1;
    s1 = {down, up, right, left};
    if (rst_n) begin
      p = period_of(speed);
      old_pend = m_pend;
      if (rq != 4'b0 && rq != opposite(m_dir)) m_pend = rq;
      if (m_out) begin
        if (step_ready) begin
          m_dir = old_pend;
          m_out = 0;
          m_run = enable;
          rem   = p;
        end else begin
          rem--;
          if (rem == 0) begin
            m_ovr = 1;
            rem   = p;
          end
        end
      end else if (m_run) begin
        if (!enable) m_run = 0;
        else begin
          rem--;
          if (rem == 0) begin
            m_out = 1;
            rem   = p;
          end
        end
      end else if (enable) begin
        m_run = 1;
        rem   = p;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {down, up, right, left} = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if (step_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", step_valid); end
    checks++;
    if (direction !== 4'b0010) begin errors++; $display("FAIL reset_dir: got %b want 0010", direction); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (step_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", step_valid); end
  endtask

  task automatic test_steady();
    int t[$];
    enable = 1'b1;
    speed = 2'd0;
    step_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if ({step_valid, direction, overrun} !== {m_out, m_dir, m_ovr}) begin
        errors++;
        $display("FAIL steady cyc%0d: got v=%b d=%b o=%b want v=%b d=%b o=%b",
                 cyc, step_valid, direction, overrun, m_out, m_dir, m_ovr);
      end
      if (step_valid === 1'b1) t.push_back(cyc);
    end
    checks++;
    if (t.size() < 3) begin errors++; $display("FAIL steady_count: got %0d steps want >=3", t.size()); end
    for (int i = 1; i < t.size(); i++) begin
      checks++;
      if (t[i] - t[i-1] != 9) begin
        errors++;
        $display("FAIL steady_spacing: got %0d cycles want 9", t[i] - t[i-1]);
      end
    end
    checks++;
    if (direction !== 4'b0010) begin errors++; $display("FAIL steady_dir: got %b want 0010", direction); end
  endtask

  // Waits for the next step and lets the accept edge pass (ready must be 1).
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (step_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (step_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got step_valid=%b want 1 within 50 cycles", tag, step_valid);
    end
    tick();
  endtask

  task automatic test_reverse_filter();
    wait_accept("rev_sync");
    set_btn(4'b0001);
    repeat (3) tick();
    set_btn(4'b0000);
    wait_accept("rev_step");
    checks++;
    if (direction !== 4'b0010) begin errors++; $display("FAIL reverse_dir: got %b want 0010", direction); end
    checks++;
    if (m_dir !== direction) begin errors++; $display("FAIL reverse_model: got %b want %b", direction, m_dir); end
  endtask

  task automatic test_up_down();
    wait_accept("ud_sync");
    set_btn(4'b0100);
    repeat (2) tick();
    set_btn(4'b1000);
    repeat (2) tick();
    set_btn(4'b0000);
    checks++;
    if (direction !== 4'b0010) begin errors++; $display("FAIL ud_before: got %b want 0010", direction); end
    wait_accept("ud_step");
    checks++;
    if (direction !== 4'b1000) begin errors++; $display("FAIL ud_dir: got %b want 1000", direction); end
  endtask

  task automatic test_overrun();
    int n;
    step_ready = 1'b0;
    n = 0;
    while (step_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (step_valid !== 1'b1) begin errors++; $display("FAIL ovr_timeout: got %b want 1", step_valid); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({step_valid, direction} !== {1'b1, 4'b1000} || overrun !== (i >= 8)) begin
        errors++;
        $display("FAIL ovr_hold wait%0d: got v=%b d=%b o=%b want v=1 d=1000 o=%b",
                 i, step_valid, direction, overrun, (i >= 8));
      end
    end
    step_ready = 1'b1;
    tick();
    checks++;
    if ({step_valid, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_accept: got v=%b o=%b want v=0 o=1", step_valid, overrun);
    end
  endtask

  task automatic test_speed(input logic [1:0] s, input int spacing);
    int t[$];
    speed = s;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if ({step_valid, direction, overrun} !== {m_out, m_dir, m_ovr}) begin
        errors++;
        $display("FAIL speed%0d cyc%0d: got v=%b d=%b o=%b want v=%b d=%b o=%b",
                 s, cyc, step_valid, direction, overrun, m_out, m_dir, m_ovr);
      end
      if (step_valid === 1'b1) t.push_back(cyc);
    end
    checks++;
    if (t.size() < 3 || t[t.size()-1] - t[t.size()-2] != spacing) begin
      errors++;
      $display("FAIL speed%0d_spacing: got %0d steps last gap %0d want gap %0d", s, t.size(),
               (t.size() >= 2) ? t[t.size()-1] - t[t.size()-2] : -1, spacing);
    end
  endtask

  task automatic test_async_reset();
    int n;
    speed = 2'd0;
    step_ready = 1'b0;
    n = 0;
    while (step_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if ({step_valid, overrun} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre: got v=%b o=%b want v=1 o=1", step_valid, overrun);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({step_valid, direction, overrun} !== {1'b0, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL arst_async: got v=%b d=%b o=%b want v=0 d=0010 o=0", step_valid, direction, overrun);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    step_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] b;
    b = 4'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) b = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
      set_btn(b);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 40) == 0) speed = 2'($urandom);
      step_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if ({step_valid, direction, overrun} !== {m_out, m_dir, m_ovr}) begin
        errors++;
        $display("FAIL random cyc%0d: got v=%b d=%b o=%b want v=%b d=%b o=%b",
                 cyc, step_valid, direction, overrun, m_out, m_dir, m_ovr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_btn(4'b0);
    enable = 1'b0;
    speed = 2'd0;
    step_ready = 1'b0;
    s1 = 4'b0;
    s2 = 4'b0;
    model_reset();
    test_reset();
    test_steady();
    test_reverse_filter();
    test_up_down();
    test_overrun();
    test_speed(2'd2, 3);
    test_speed(2'd3, 2);
    test_async_reset();
    speed = 2'd3;
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
